mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control FSM that sequences the shared ALU, register file, memory and PC of the multi-cycle MIPS core.
- Latches the instruction class in DECODE.
- Drives ALUOp/ALUSrc/shamt-select and all write enables state by state.
- Consumes the ALU's zero/overflow flags to resolve branches and overflow writeback.

Parameters:
- STATE_W, 4, width of the state register and debug port.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  6  IR[31:26].
- funct  input  6  IR[5:0].
- zero  input  1  ALU zero flag.
- overflow  input  1  ALU overflow flag, already gated by write_30.
- pc_write  output  1  PC load enable.
- pc_src  output  2  PC mux select: 00 = PC+4, 01 = branch target, 10 = jump target.
- ir_write  output  1  IR load enable.
- ALUOp  output  3  ALU operation: 000 add, 001 sub, 010 or, 011 slt, 100 sll, 101 sign test.
- ALUSrc  output  1  ALU B operand: 0 = rt data, 1 = ext32.
- ext_op  output  2  extender mode: 00 zero, 01 sign, 10 lui (imm<<16).
- reg_dst  output  2  write register select: 00 rt, 01 rd, 10 $30.
- mem_to_reg  output  2  writeback data select: 00 ALU, 01 memory, 10 constant 1.
- reg_write  output  1  register file write enable.
- mem_write  output  1  data memory write enable.
- write_30  output  1  enables the ALU overflow flag.
- instr_done  output  1  one-cycle pulse in the last state of each instruction.
- state  output  STATE_W  current state (debug).

Behaviour:
- Clock and reset
  - Single clock; reset is synchronous and active-high.
  - While reset is high at a clock edge: state <= FETCH, class register <= NOP.
  - All enables (pc_write, ir_write, reg_write, mem_write, instr_done) are forced 0 while reset is high.
  - ALUOp, ALUSrc, ext_op, reg_dst, mem_to_reg, pc_src and write_30 are 0 during reset.
- Output style: Moore. Outputs decode from the registered state plus the class latched at the DECODE exit edge. Changes on op/funct after DECODE are ignored.
- States (4-bit encoding): FETCH, DECODE, EXE, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP.
- FETCH
  - ir_write=1, pc_write=1, pc_src=00.
  - Always goes to DECODE.
- DECODE: class decoded from op/funct.
  - R-type (addu 100001, subu 100011, slt 101010, sll 000000, add 100000), ori 001101, lui 001111, addi 001000, lw 100011, sw 101011 -> EXE.
  - beq 000100, bltz 000001 -> BRANCH.
  - j 000010 -> JUMP.
  - Any other encoding -> FETCH as a NOP, with instr_done=1.
- EXE: ALU setup by class.
  - addu/add/addi/lw/sw: ALUOp=000.
  - subu: ALUOp=001.
  - ori: ALUOp=010, ext_op=00.
  - slt: ALUOp=011.
  - sll: ALUOp=100.
  - lui: ALUOp=010 with A=$0 assumed by datapath, ext_op=10.
  - ALUSrc=1 for I-type; lw/sw/addi use ext_op=01.
  - Next state: lw -> MEM_RD, sw -> MEM_WR, others -> WB_ALU.
- MEM_RD -> WB_MEM.
- MEM_WR: mem_write=1, instr_done=1 -> FETCH.
- WB_ALU: reg_write=1, mem_to_reg=00, reg_dst=01 for R-type and 00 for I-type; instr_done=1 -> FETCH.
- WB_MEM: reg_write=1, mem_to_reg=01, reg_dst=00; instr_done=1 -> FETCH.
- BRANCH: ALUSrc=0, instr_done=1 -> FETCH.
  - beq: ALUOp=001; pc_write=zero; pc_src=01.
  - bltz: ALUOp=101; pc_write=~zero; pc_src=01.
- JUMP: pc_write=1, pc_src=10, instr_done=1 -> FETCH.
- Latency in cycles: ALU ops 4, lw 5, sw 4, beq/bltz/j 3, NOP 2.
- Reset mid-instruction: at the reset edge, any write enable for the interrupted instruction is suppressed; no partial writeback occurs.
- The ALU's shamt input is sourced from IR[10:6] by the datapath. The controller only selects ALUOp=100 for sll.

Optional Feature:
- Macro: OVF_TRAP_EN.
- Defined
  - write_30=1 in EXE and WB_ALU for add and addi.
  - In WB_ALU, if overflow=1, the writeback is redirected: reg_dst=10, mem_to_reg=10, so $30 <= 1. rd/rt is not written.
  - If overflow=0, normal writeback.
- Undefined
  - write_30 is tied 0 and overflow is ignored.
  - add/addi behave identically to addu/addiu.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct constants;
  - ALUOp encodings (ALU_ADD..ALU_SGN);
  - state encoding;
  - class enum (C_RALU, C_IALU, C_LUI, C_LW, C_SW, C_BEQ, C_BLTZ, C_J, C_ADDOV, C_NOP);
  - pc_src, reg_dst and mem_to_reg select constants.
- One combinational sub-module, mc_decode: maps op/funct to class, ALUOp, ALUSrc and ext_op. The FSM registers its class output in DECODE.

Test Plan:
- Reset held 2 cycles then released -> state=FETCH, all enables 0 during reset; first cycle after release has ir_write=1, pc_write=1.
- addu (op 0, funct 100001) -> 4 cycles; ALUOp=000 in EXE; reg_write=1 with reg_dst=01 only in WB_ALU; instr_done pulse in cycle 4.
- lw then sw -> lw takes 5 cycles with mem_to_reg=01 in WB_MEM, ALUSrc=1, ext_op=01; sw takes 4 cycles with mem_write=1 only in MEM_WR, reg_write never 1.
- Branches:
  - beq with zero=1 -> pc_write=1, pc_src=01 in BRANCH.
  - beq with zero=0 -> pc_write=0.
  - bltz with zero=0 -> pc_write=1 and ALUOp=101.
- Undefined op 111111 -> DECODE returns to FETCH, instr_done=1, no writes; reset asserted in WB_ALU of an addu -> reg_write=0 that cycle, state=FETCH next.
- With OVF_TRAP_EN: add with overflow=1 -> WB_ALU drives reg_dst=10, mem_to_reg=10, reg_write=1; overflow=0 -> reg_dst=01. Without the macro: write_30=0 throughout.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, ALU ops,
// FSM states, instruction classes and datapath mux selects.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_ADD   = 6'b100000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_SGN  = 3'b101;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_R30   = 2'b10;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_MEM  = 2'b01;
    localparam logic [1:0] M2R_ONE  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE    = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB_ALU = 4'd5,
        S_WB_MEM = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8
    } state_e;

    typedef enum logic [3:0] {
        C_RALU, C_IALU, C_LUI, C_LW, C_SW, C_BEQ, C_BLTZ, C_J, C_ADDOV, C_NOP
    } class_e;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in, control strobes out.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic [2:0] ALUOp;
    logic       ALUSrc;
    logic [1:0] ext_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       write_30;
    logic       instr_done;

    modport master (
        input  op, funct, zero, overflow,
        output pc_write, pc_src, ir_write, ALUOp, ALUSrc, ext_op, reg_dst,
               mem_to_reg, reg_write, mem_write, write_30, instr_done
    );

    modport slave (
        output op, funct, zero, overflow,
        input  pc_write, pc_src, ir_write, ALUOp, ALUSrc, ext_op, reg_dst,
               mem_to_reg, reg_write, mem_write, write_30, instr_done
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decoder: op/funct -> class and ALU setup.
// With OVF_TRAP_EN defined, add/addi map to the overflow-trapping class C_ADDOV.
module mc_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output class_e     cls_o,
    output logic [2:0] alu_op_o,
    output logic       alu_src_o,
    output logic [1:0] ext_op_o
);

    always_comb begin
        cls_o     = C_NOP;
        alu_op_o  = ALU_ADD;
        alu_src_o = 1'b0;
        ext_op_o  = EXT_ZERO;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU: cls_o = C_RALU;
                    FN_ADD: begin
`ifdef OVF_TRAP_EN
                        cls_o = C_ADDOV;
`else
                        cls_o = C_RALU;
`endif
                    end
                    FN_SUBU: begin cls_o = C_RALU; alu_op_o = ALU_SUB; end
                    FN_SLT:  begin cls_o = C_RALU; alu_op_o = ALU_SLT; end
                    FN_SLL:  begin cls_o = C_RALU; alu_op_o = ALU_SLL; end
                    default: cls_o = C_NOP;
                endcase
            end
            OP_ORI:  begin cls_o = C_IALU; alu_op_o = ALU_OR; alu_src_o = 1'b1; end
            // lui relies on the datapath presenting $0 on A, so OR yields imm<<16
            OP_LUI:  begin cls_o = C_LUI; alu_op_o = ALU_OR; alu_src_o = 1'b1; ext_op_o = EXT_LUI; end
            OP_ADDI: begin
`ifdef OVF_TRAP_EN
                cls_o = C_ADDOV;
`else
                cls_o = C_IALU;
`endif
                alu_src_o = 1'b1;
                ext_op_o  = EXT_SIGN;
            end
            OP_LW:   begin cls_o = C_LW; alu_src_o = 1'b1; ext_op_o = EXT_SIGN; end
            OP_SW:   begin cls_o = C_SW; alu_src_o = 1'b1; ext_op_o = EXT_SIGN; end
            OP_BEQ:  begin cls_o = C_BEQ; alu_op_o = ALU_SUB; end
            OP_BLTZ: begin cls_o = C_BLTZ; alu_op_o = ALU_SGN; end
            OP_J:    cls_o = C_J;
            default: cls_o = C_NOP;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM; class and ALU setup are latched on leaving DECODE.
// OVF_TRAP_EN enables write_30 and the $30 <= 1 overflow redirect for add/addi.
module mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    mc_ctrl_if.master          bus,
    output logic [STATE_W-1:0] state
);

    state_e     state_q, state_d;
    class_e     cls_q, dec_cls;
    logic [2:0] alu_op_q, dec_alu_op;
    logic       alu_src_q, dec_alu_src;
    logic [1:0] ext_op_q, dec_ext_op;
    logic       addov;

    mc_decode u_dec (
        .op_i      (bus.op),
        .funct_i   (bus.funct),
        .cls_o     (dec_cls),
        .alu_op_o  (dec_alu_op),
        .alu_src_o (dec_alu_src),
        .ext_op_o  (dec_ext_op)
    );

`ifdef OVF_TRAP_EN
    assign addov = (cls_q == C_ADDOV);
`else
    logic unused_ovf;
    assign addov      = 1'b0;
    assign unused_ovf = bus.overflow;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cls_q     <= C_NOP;
            alu_op_q  <= ALU_ADD;
            alu_src_q <= 1'b0;
            ext_op_q  <= EXT_ZERO;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q     <= dec_cls;
                alu_op_q  <= dec_alu_op;
                alu_src_q <= dec_alu_src;
                ext_op_q  <= dec_ext_op;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.pc_write   = 1'b0;
        bus.pc_src     = PC_PLUS4;
        bus.ir_write   = 1'b0;
        bus.ALUOp      = ALU_ADD;
        bus.ALUSrc     = 1'b0;
        bus.ext_op     = EXT_ZERO;
        bus.reg_dst    = RD_RT;
        bus.mem_to_reg = M2R_ALU;
        bus.reg_write  = 1'b0;
        bus.mem_write  = 1'b0;
        bus.write_30   = 1'b0;
        bus.instr_done = 1'b0;

        // ALU setup stays applied from EXE through writeback; the datapath has no ALU output latch
        if (state_q inside {S_EXE, S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM}) begin
            bus.ALUOp  = alu_op_q;
            bus.ALUSrc = alu_src_q;
            bus.ext_op = ext_op_q;
        end

        case (state_q)
            S_FETCH: begin
                bus.ir_write = 1'b1;
                bus.pc_write = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                case (dec_cls)
                    C_BEQ, C_BLTZ: state_d = S_BRANCH;
                    C_J:           state_d = S_JUMP;
                    C_NOP: begin
                        bus.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end
                    default:       state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                bus.write_30 = addov;
                case (cls_q)
                    C_LW:    state_d = S_MEM_RD;
                    C_SW:    state_d = S_MEM_WR;
                    default: state_d = S_WB_ALU;
                endcase
            end
            S_MEM_RD: state_d = S_WB_MEM;
            S_MEM_WR: begin
                bus.mem_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_WB_ALU: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = alu_src_q ? RD_RT : RD_RD;
                bus.write_30   = addov;
                if (addov && bus.overflow) begin
                    bus.reg_dst    = RD_R30;
                    bus.mem_to_reg = M2R_ONE;
                end
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = M2R_MEM;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUOp      = alu_op_q;
                bus.pc_src     = PC_BRANCH;
                bus.pc_write   = (cls_q == C_BLTZ) ? ~bus.zero : bus.zero;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_src     = PC_JUMP;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset suppresses every strobe, including those of an interrupted instruction
        if (reset) begin
            bus.pc_write   = 1'b0;
            bus.pc_src     = PC_PLUS4;
            bus.ir_write   = 1'b0;
            bus.ALUOp      = ALU_ADD;
            bus.ALUSrc     = 1'b0;
            bus.ext_op     = EXT_ZERO;
            bus.reg_dst    = RD_RT;
            bus.mem_to_reg = M2R_ALU;
            bus.reg_write  = 1'b0;
            bus.mem_write  = 1'b0;
            bus.write_30   = 1'b0;
            bus.instr_done = 1'b0;
        end
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed + random instruction stream against a per-cycle
// expectation built from instruction kind, cycle index and the ALU flags.
module tb_mc_ctrl;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] state_dbg;
    int         n_vec = 0;
    int         n_err = 0;

    mc_ctrl_if bus ();

    mc_ctrl #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master),
        .state (state_dbg)
    );

    always #5 clk = ~clk;

    logic [17:0] dut_vec;
    assign dut_vec = {bus.pc_write, bus.pc_src, bus.ir_write, bus.ALUOp, bus.ALUSrc,
                      bus.ext_op, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                      bus.mem_write, bus.write_30, bus.instr_done};

    // kinds: 0 addu 1 subu 2 slt 3 sll 4 add 5 ori 6 lui 7 addi 8 lw 9 sw
    //        10 beq 11 bltz 12 j 13 undefined op 14 undefined R-type funct
    localparam int NK = 15;
    logic [5:0] k_op [NK] = '{6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'b001101, 6'b001111,
                              6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000001,
                              6'b000010, 6'b111111, 6'o00};
    logic [5:0] k_fn [NK] = '{6'b100001, 6'b100011, 6'b101010, 6'b000000, 6'b100000,
                              6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'b111111};
    logic [2:0] k_aop [NK] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0,
                               3'd1, 3'd5, 3'd0, 3'd0, 3'd0};
    logic [1:0] k_ext [NK] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1,
                               2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    int         k_len [NK] = '{4, 4, 4, 4, 4, 4, 4, 4, 5, 4, 3, 3, 3, 2, 2};

`ifdef OVF_TRAP_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] model(int kind, int k, logic z, logic ov);
        logic       pw = 0, irw = 0, src = 0, rw = 0, mw = 0, w30 = 0, done = 0;
        logic [1:0] ps = 0, ext = 0, rdst = 0, m2r = 0;
        logic [2:0] aop = 0;
        logic       ovf_add = OVF && (kind == 4 || kind == 7);
        if (k == 0) begin
            pw = 1; irw = 1;
        end else if (kind >= 13) begin
            done = (k == 1);
        end else if (k >= 2) begin
            if (kind == 10 || kind == 11) begin
                aop = k_aop[kind]; ps = 2'b01; done = 1;
                pw = (kind == 10) ? z : !z;
            end else if (kind == 12) begin
                pw = 1; ps = 2'b10; done = 1;
            end else begin
                aop = k_aop[kind]; ext = k_ext[kind]; src = (kind >= 5);
                w30 = ovf_add;
                if (kind == 9 && k == 3) begin mw = 1; done = 1; end
                if (kind == 8 && k == 4) begin rw = 1; m2r = 2'b01; done = 1; end
                if (kind <= 7 && k == 3) begin
                    rw = 1; done = 1;
                    rdst = (kind <= 4) ? 2'b01 : 2'b00;
                    if (ovf_add && ov) begin rdst = 2'b10; m2r = 2'b10; end
                end
            end
        end
        return {pw, ps, irw, aop, src, ext, rdst, m2r, rw, mw, w30, done};
    endfunction

    function automatic bit valid_op(logic [5:0] o);
        return o inside {6'b000000, 6'b001101, 6'b001111, 6'b001000, 6'b100011,
                         6'b101011, 6'b000100, 6'b000001, 6'b000010};
    endfunction

    // Called at a negedge while the DUT sits in FETCH; returns at the negedge after the last cycle.
    task automatic run_instr(input int kind, input logic z, input logic ov, input int reset_at);
        logic [5:0] o, f;
        o = k_op[kind];
        f = (kind <= 4 || kind == 14) ? k_fn[kind] : 6'($urandom);
        if (kind == 13) begin
            o = 6'($urandom);
            while (valid_op(o)) o = 6'($urandom);
        end
        for (int k = 0; k < k_len[kind]; k++) begin
            if (k == 0) begin
                bus.op = o; bus.funct = f; bus.zero = z; bus.overflow = ov;
            end
            if (k == 2) begin
                bus.op = 6'($urandom); bus.funct = 6'($urandom);
            end
            if (k == reset_at) begin
                reset = 1'b1;
                #1 chk($sformatf("rst_mid k%0d c%0d", kind, k), 32'(dut_vec), 32'd0);
                @(negedge clk);
                chk("rst_mid_state", 32'(state_dbg), 32'(S_FETCH));
                reset = 1'b0;
                return;
            end
            #1 chk($sformatf("kind%0d cyc%0d z%0b ov%0b", kind, k, z, ov),
                   32'(dut_vec), 32'(model(kind, k, z, ov)));
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.overflow = 1'b0;
        @(negedge clk);
        chk("rst_out0", 32'(dut_vec), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(S_FETCH));
        @(negedge clk);
        chk("rst_out1", 32'(dut_vec), 32'd0);
        reset = 1'b0;

        run_instr(0, 1'b0, 1'b0, -1);   // addu
        run_instr(8, 1'b0, 1'b0, -1);   // lw
        run_instr(9, 1'b0, 1'b0, -1);   // sw
        run_instr(10, 1'b1, 1'b0, -1);  // beq taken
        run_instr(10, 1'b0, 1'b0, -1);  // beq not taken
        run_instr(11, 1'b0, 1'b0, -1);  // bltz taken
        run_instr(11, 1'b1, 1'b0, -1);  // bltz not taken
        run_instr(12, 1'b0, 1'b0, -1);  // j
        run_instr(13, 1'b0, 1'b0, -1);
        run_instr(14, 1'b0, 1'b0, -1);
        run_instr(4, 1'b0, 1'b1, -1);   // add, overflow
        run_instr(4, 1'b0, 1'b0, -1);
        run_instr(7, 1'b0, 1'b1, -1);   // addi, overflow
        run_instr(6, 1'b0, 1'b0, -1);   // lui
        run_instr(3, 1'b0, 1'b0, -1);   // sll
        run_instr(0, 1'b0, 1'b0, 3);    // addu interrupted in WB_ALU
        run_instr(0, 1'b0, 1'b0, -1);

        for (int i = 0; i < 300; i++) begin
            int kind, rat;
            kind = int'($urandom_range(NK - 1));
            rat  = ($urandom_range(15) == 0) ? int'($urandom_range(k_len[kind] - 1)) : -1;
            run_instr(kind, 1'($urandom), 1'($urandom), rat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
